// File: rtl/int_replay_window_unit.sv
// Replay shadow window for the integer issue stage: records issued ops for DEPTH cycles
// and replays ops younger than a mis-speculated load, oldest stage first.
module int_replay_window_unit #(
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 2,
    parameter int PACK_W  = 96,
    parameter int TAG_W   = 6,
    parameter int TAG_LSB = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [TAG_W-1:0]                   commit_tag,
    input  logic                               hold,
    input  logic                               flush_valid,
    input  logic [TAG_W-1:0]                   flush_tag,
    input  logic                               replay_req,
    input  logic [TAG_W-1:0]                   replay_tag,
    input  logic [ISSUE_W-1:0]                 issue_valid,
    input  logic [ISSUE_W*PACK_W-1:0]          issue_pack,
    output logic                               replay_active,
    output logic [ISSUE_W-1:0]                 replay_valid,
    output logic [ISSUE_W*PACK_W-1:0]          replay_pack,
    output logic [$clog2(ISSUE_W*DEPTH+1)-1:0] occupancy,
    output logic                               replay_overrun,
    output logic [15:0]                        replay_events
);

    localparam int SEL_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(ISSUE_W*DEPTH+1);

    typedef enum logic {IDLE, REPLAY} state_t;

    state_t             state_q, state_d;
    logic [ISSUE_W-1:0] valid_q [DEPTH];
    logic [ISSUE_W-1:0] valid_d [DEPTH];
    logic [ISSUE_W-1:0] mark_q  [DEPTH];
    logic [ISSUE_W-1:0] mark_d  [DEPTH];
    logic [PACK_W-1:0]  pack_q  [DEPTH][ISSUE_W];
    logic [PACK_W-1:0]  pack_d  [DEPTH][ISSUE_W];
    logic [15:0]        events_q, events_d;
    logic               overrun_q, overrun_d;
    logic [SEL_W-1:0]   sel_stage;
    logic               sel_any;
    logic               marks_left;

    // Modular age relative to the ROB head: larger age means younger op.
    function automatic logic is_younger(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b,
                                        input logic [TAG_W-1:0] ref_tag);
        logic [TAG_W-1:0] age_a;
        logic [TAG_W-1:0] age_b;
        age_a = a - ref_tag;
        age_b = b - ref_tag;
        return age_a > age_b;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Oldest stage still holding marked entries; ascending scan so the highest index wins.
    always_comb begin
        sel_stage = '0;
        sel_any   = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (|mark_q[k]) begin
                sel_stage = SEL_W'(k);
                sel_any   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        mark_d     = mark_q;
        pack_d     = pack_q;
        events_d   = events_q;
        overrun_d  = 1'b0;
        marks_left = 1'b0;

        if (state_q == IDLE) begin
            for (int k = 0; k < DEPTH; k++) mark_d[k] = '0;
            // A replay request captures the current issue lanes even under hold.
            if (!hold || replay_req) begin
                for (int k = DEPTH-1; k > 0; k--) begin
                    valid_d[k] = valid_q[k-1];
                    pack_d[k]  = pack_q[k-1];
                end
                valid_d[0] = issue_valid;
                for (int i = 0; i < ISSUE_W; i++) pack_d[0][i] = issue_pack[i*PACK_W +: PACK_W];
            end
        end else begin
            overrun_d = replay_req;
            if (!hold && sel_any) begin
                valid_d[sel_stage] = '0;
                mark_d[sel_stage]  = '0;
            end
        end

        // Branch kill precedes replay marking so only survivors can be replayed.
        if (flush_valid) begin
            for (int k = 0; k < DEPTH; k++) begin
                for (int i = 0; i < ISSUE_W; i++) begin
                    if (is_younger(pack_d[k][i][TAG_LSB +: TAG_W], flush_tag, commit_tag)) begin
                        valid_d[k][i] = 1'b0;
                        mark_d[k][i]  = 1'b0;
                    end
                end
            end
        end

        if (state_q == IDLE && replay_req) begin
            events_d = sat_inc16(events_q);
            for (int k = 0; k < DEPTH; k++) begin
                for (int i = 0; i < ISSUE_W; i++) begin
                    mark_d[k][i] = valid_d[k][i] &&
                                   is_younger(pack_d[k][i][TAG_LSB +: TAG_W], replay_tag, commit_tag);
                end
            end
            valid_d = mark_d;
        end

        for (int k = 0; k < DEPTH; k++) marks_left = marks_left | (|mark_d[k]);
        state_d = marks_left ? REPLAY : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            events_q  <= '0;
            overrun_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                valid_q[k] <= '0;
                mark_q[k]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            events_q  <= events_d;
            overrun_q <= overrun_d;
            valid_q   <= valid_d;
            mark_q    <= mark_d;
        end
    end

    // Pack payloads are qualified by valid/mark, so they carry no reset.
    always_ff @(posedge clk) begin
        pack_q <= pack_d;
    end

    assign replay_active  = (state_q == REPLAY);
    assign replay_overrun = overrun_q;
    assign replay_events  = events_q;

    always_comb begin
        replay_valid = '0;
        replay_pack  = '0;
        if (replay_active) begin
            replay_valid = mark_q[sel_stage];
            for (int i = 0; i < ISSUE_W; i++) replay_pack[i*PACK_W +: PACK_W] = pack_q[sel_stage][i];
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            for (int i = 0; i < ISSUE_W; i++) occupancy = occupancy + OCC_W'(valid_q[k][i]);
        end
    end

endmodule
